// File: rtl/data_pipe_pkg.sv
// Shared definitions for the producer/processor pipe: mode codes,
// path-control FSM states and the per-beat processing operation.
package data_pipe_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_ROL  = 2'b11;

  // Widest data path the op helper supports.
  localparam int unsigned OP_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_PROC  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_BYP   = 2'd2
  } state_e;

  // Applies the selected op to the low w bits of d; bits above w are cleared.
  function automatic logic [OP_MAX_W-1:0] apply_op(
    input logic [OP_MAX_W-1:0] d,
    input logic [1:0]          mode,
    input int unsigned         w
  );
    logic [OP_MAX_W-1:0] mask;
    logic [OP_MAX_W-1:0] r;
    mask = (w >= OP_MAX_W) ? '1 : ((OP_MAX_W'(1) << w) - OP_MAX_W'(1));
    case (mode)
      MODE_PASS: r = d;
      MODE_INC:  r = d + OP_MAX_W'(1);
      MODE_INV:  r = ~d;
      MODE_ROL:  r = (d << 1) | (d >> (w - 1));
      default:   r = d;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/data_prod_proc_pipe_fifo.sv
// Output FIFO with occupancy level. A push at full is accepted when a pop
// happens in the same cycle; there is no fall-through at empty.
module sync_fifo
  import data_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic                     accept_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q;
  logic              do_push, do_pop, full;

  assign full     = (level_q == LW'(DEPTH));
  assign valid_o  = (level_q != '0);
  assign do_pop   = pop_i && valid_o;
  assign accept_o = !full || do_pop;
  assign do_push  = push_i && accept_o;
  assign data_o   = valid_o ? mem_q[rptr_q] : '0;
  assign level_o  = level_q;

  // Pointer and level bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/data_prod_proc_pipe.sv
// Counting producer, one-register processing stage, drain-before-switch
// bypass control and an output FIFO with valid/ready handshake.
module data_prod_proc_pipe
  import data_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       DEPTH  = 4,
  parameter logic [DATA_W-1:0] SEED   = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic                   bypass_en,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [DATA_W-1:0]      data_out,
  output logic                   bypass_active,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       beat_count
);

  state_e            st_q, st_d;
  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] stage_data_q, stage_d;
  logic              stage_vld_q;
  logic [CNT_W-1:0]  beat_q;

  logic              prod_valid, prod_hs, stage_load;
  logic              fifo_push, fifo_accept;
  logic [DATA_W-1:0] fifo_wdata;
  logic              pop;

  assign prod_valid    = enable && (st_q != ST_DRAIN);
  assign stage_d       = DATA_W'(apply_op(OP_MAX_W'(cnt_q), mode, DATA_W));
  assign pop           = valid_out && ready_out;
  assign bypass_active = (st_q == ST_BYP);
  assign beat_count    = beat_q;

  // Path steering: producer feeds the FIFO directly in BYP, otherwise the stage does.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_wdata = stage_data_q;
    stage_load = 1'b0;
    prod_hs    = 1'b0;
    if (st_q == ST_BYP) begin
      fifo_push  = prod_valid;
      fifo_wdata = cnt_q;
      prod_hs    = prod_valid && fifo_accept;
    end else begin
      fifo_push  = stage_vld_q;
      stage_load = !stage_vld_q || fifo_accept;
      prod_hs    = prod_valid && stage_load;
    end
  end

  // Next path state: every switch passes through DRAIN until the stage is empty.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_PROC:  if (bypass_en)   st_d = ST_DRAIN;
      ST_BYP:   if (!bypass_en)  st_d = ST_DRAIN;
      ST_DRAIN: if (!stage_vld_q) st_d = bypass_en ? ST_BYP : ST_PROC;
      default:  st_d = ST_PROC;
    endcase
  end

  // Control registers: FSM, producer counter, stage valid, handshake counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= ST_PROC;
      cnt_q       <= SEED;
      stage_vld_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      st_q <= st_d;
      if (prod_hs)    cnt_q       <= cnt_q + DATA_W'(1);
      if (stage_load) stage_vld_q <= prod_hs;
      if (pop)        beat_q      <= beat_q + CNT_W'(1);
    end
  end

  // Stage data register; mode is applied as the beat enters.
  always_ff @(posedge clk) begin
    if (stage_load && prod_hs) stage_data_q <= stage_d;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (rst),
    .push_i   (fifo_push),
    .data_i   (fifo_wdata),
    .pop_i    (ready_out),
    .accept_o (fifo_accept),
    .valid_o  (valid_out),
    .data_o   (data_out),
    .level_o  (fifo_level)
  );

endmodule

// File: doc/data_prod_proc_pipe.md
Name: data_prod_proc_pipe

Overview:
- Parametrised successor of the producer/processor pair. Contains an internal counting producer, a registered processing stage with four modes, a bypass path and an output FIFO with a valid/ready handshake.
- Adds four things the previous pair lacks: configurable width and depth, safe run-time bypass switching that drains before it switches, back-pressure absorption, and status counters.
- Sits between stimulus generation and downstream consumers in the data path.

Parameters:
- DATA_W, 8: data and producer counter width.
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- SEED, 0: producer counter value after reset (DATA_W bits).
- CNT_W, 16: width of beat_count.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: producer emits beats while high.
- mode, input, 2: processing op, sampled per beat when it enters the stage.
- bypass_en, input, 1: requested path; 1 = skip processing.
- valid_out, output, 1: FIFO non-empty.
- ready_out, input, 1: consumer ready.
- data_out, output, DATA_W: FIFO head; 0 when empty.
- bypass_active, output, 1: path currently in force.
- fifo_level, output, $clog2(DEPTH)+1: current occupancy.
- beat_count, output, CNT_W: count of output handshakes; wraps.

Behaviour:
- Reset (rst low, async): valid_out=0, data_out=0, bypass_active=0, fifo_level=0, beat_count=0. Producer counter=SEED, stage empty, FSM=PROC, FIFO pointers 0. Reset applied mid-transfer discards all in-flight data.
- Producer:
  - prod_valid = enable && FSM≠DRAIN.
  - prod_data = counter.
  - Counter increments by 1 mod 2^DATA_W on each prod handshake only.
- Processing stage: one register plus a valid bit. Ops by mode:
  - 00 pass
  - 01 +1 mod 2^DATA_W
  - 10 bitwise invert
  - 11 rotate left by 1
- Stage acceptance: the stage loads when empty, or when its content is written to the FIFO in the same cycle.
- FIFO write source: stage output in PROC, producer output in BYP.
- FIFO write rule: accepted when !full, or when full and a pop occurs in the same cycle (simultaneous push/pop at full is legal; level unchanged).
- Pop = valid_out && ready_out. Simultaneous push/pop at empty: the data goes in and the level goes to 1; no fall-through.
- Latency from producer handshake to valid_out (empty FIFO):
  - PROC: 2 cycles.
  - BYP: 1 cycle.
- Back-pressure: a full FIFO stalls the stage, which stalls the producer. No beat is dropped or duplicated; counter values stay contiguous.
- FSM states PROC, DRAIN, BYP; bypass_active=1 only in BYP.
  - PROC→DRAIN when bypass_en=1.
  - BYP→DRAIN when bypass_en=0.
  - In DRAIN the producer is held (prod_valid=0) until the stage is empty.
  - DRAIN exits to the state matching the current bypass_en; if the request reverted during the drain, it returns to the origin state.
  - BYP→DRAIN needs no stage drain; it exits the next cycle.
- Ordering: output order always equals producer order across every path switch.
- mode changes take effect on the next beat entering the stage; beats already in the stage or FIFO are unaffected.
- beat_count increments on each pop and wraps at 2^CNT_W.

Decomposition:
- Package data_pipe_pkg holds:
  - mode localparams MODE_PASS/MODE_INC/MODE_INV/MODE_ROL;
  - FSM state enum ST_PROC/ST_DRAIN/ST_BYP;
  - the combinational op function.
- Sub-module sync_fifo: parametrised DATA_W/DEPTH, with level output and the push-at-full-with-pop rule. The top holds the producer, stage, FSM and counters.

Test Plan (DATA_W=8, DEPTH=4, SEED=0):
- Reset release, mode=00, enable=1, ready_out=1 → valid_out rises 2 cycles after the first handshake; data_out 0,1,2,3… one per cycle; beat_count tracks.
- mode=01 run over the wrap → outputs …0xFE,0xFF,0x00 for counters 0xFD,0xFE,0xFF; no glitch or drop.
- ready_out=0 for 10 cycles → fifo_level saturates at 4, stage holds 4, producer stalls at counter 5; releasing ready_out yields 0..5 contiguous.
- mode=10, stream running, bypass_en 0→1 at counter 6 → outputs 0xFF,0xFE,… up to the last processed beat, then raw values. bypass_active rises only after the stage drains; no reorder or gap in the counter sequence.
- Full FIFO with ready_out=1 and a stage beat pending → push and pop in the same cycle; level stays 4; beat_count +1.
- Assert rst low mid-stream (async, between edges) → valid_out, fifo_level and beat_count go to 0 immediately. After release the stream restarts at 0x00 in PROC.
